// File: rtl/hidden_backprop_seq.sv
// hidden_backprop_seq: sequential hidden-layer weight update, one channel per cycle through a shared multiplier
//   clk_i, rst_i (async, active low), en_i (clock enable), start_i, zero_weight_reset_i (sync clear)
//   target_i, final_i, hidden_val_i, x_i, w_i  : operands captured on an accepted start
//   w_o, w_valid_o                             : updated weights and per-channel written flags
//   busy_o, done_o, sat_o                      : run in progress, completion pulse, saturation seen
module hidden_backprop_seq #(
    parameter int N_IN     = 4,
    parameter int W_W      = 8,
    parameter int H_W      = 10,
    parameter int F_W      = 19,
    parameter int LR_SHIFT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  start_i,
    input  logic                  zero_weight_reset_i,
    input  logic [F_W-1:0]        target_i,
    input  logic [F_W-1:0]        final_i,
    input  logic [H_W-1:0]        hidden_val_i,
    input  logic [N_IN-1:0]       x_i,
    input  logic [N_IN*W_W-1:0]   w_i,
    output logic [N_IN*W_W-1:0]   w_o,
    output logic [N_IN-1:0]       w_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sat_o
);
    localparam int P_W   = F_W + H_W + 3;
    localparam int S_W   = P_W + 1;
    localparam int IDX_W = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam logic [1:0] IDLE = 2'd0, GRAD = 2'd1, UPD = 2'd2, DONE = 2'd3;
    localparam logic signed [S_W-1:0] W_MAX = S_W'((1 << (W_W - 1)) - 1);
    localparam logic signed [S_W-1:0] W_MIN = -W_MAX - S_W'(1);

    logic [1:0]               state;
    logic [IDX_W-1:0]         idx;
    logic [F_W-1:0]           tgt_q, fin_q;
    logic [H_W-1:0]           h_q;
    logic [N_IN-1:0]          x_q;
    logic [N_IN*W_W-1:0]      w_q;
    logic signed [F_W+1:0]    g_q;
    logic                     gate_h;
    logic signed [F_W:0]      e;
    logic signed [P_W-1:0]    p, d;
    logic signed [W_W-1:0]    w_cur, w_new;
    logic signed [S_W-1:0]    sum;
    logic                     upd, hi, lo;

    assign e   = $signed({1'b0, tgt_q}) - $signed({1'b0, fin_q});
    assign p   = P_W'(g_q) * P_W'($signed({1'b0, h_q}));
    // arithmetic shift floors toward -inf, so tiny negative steps still move the weight
    assign d   = p >>> LR_SHIFT;
    assign sum = S_W'(d) + S_W'(w_cur);
    assign upd = x_q[idx] & gate_h;
    assign hi  = sum > W_MAX;
    assign lo  = sum < W_MIN;

    always_comb begin
        w_cur = '0;
        for (int k = 0; k < N_IN; k++)
            if (idx == IDX_W'(k)) w_cur = w_q[k*W_W +: W_W];
        w_new = !upd ? w_cur : hi ? W_MAX[W_W-1:0] : lo ? W_MIN[W_W-1:0] : sum[W_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            idx       <= '0;
            tgt_q     <= '0;
            fin_q     <= '0;
            h_q       <= '0;
            x_q       <= '0;
            w_q       <= '0;
            g_q       <= '0;
            gate_h    <= 1'b0;
            w_o       <= '0;
            w_valid_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            sat_o     <= 1'b0;
        end else if (zero_weight_reset_i) begin
            state     <= IDLE;
            idx       <= '0;
            w_o       <= '0;
            w_valid_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            sat_o     <= 1'b0;
        end else if (en_i) begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    tgt_q  <= target_i;
                    fin_q  <= final_i;
                    h_q    <= hidden_val_i;
                    x_q    <= x_i;
                    w_q    <= w_i;
                    sat_o  <= 1'b0;
                    busy_o <= 1'b1;
                    state  <= GRAD;
                end
                GRAD: begin
                    g_q    <= {e, 1'b0};
                    gate_h <= |h_q;
                    idx    <= '0;
                    state  <= UPD;
                end
                UPD: begin
                    for (int k = 0; k < N_IN; k++)
                        if (idx == IDX_W'(k)) begin
                            w_o[k*W_W +: W_W] <= w_new;
                            w_valid_o[k]      <= 1'b1;
                        end
                    if (upd && (hi || lo)) sat_o <= 1'b1;
                    idx   <= idx == IDX_W'(N_IN - 1) ? '0 : idx + 1'b1;
                    state <= idx == IDX_W'(N_IN - 1) ? DONE : UPD;
                end
                default: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hidden_backprop_seq.sv
// tb_hidden_backprop_seq: randomized and directed check of hidden_backprop_seq against an arithmetic model
module tb_hidden_backprop_seq;
    localparam int N_IN = 4, W_W = 8, H_W = 10, F_W = 19, LR = 8;

    logic                clk_i = 1'b0, rst_i = 1'b0, en_i = 1'b1, start_i = 1'b0, zwr = 1'b0;
    logic [F_W-1:0]      target_i = '0, final_i = '0;
    logic [H_W-1:0]      hidden_val_i = '0;
    logic [N_IN-1:0]     x_i = '0;
    logic [N_IN*W_W-1:0] w_i = '0;
    logic [N_IN*W_W-1:0] w_o;
    logic [N_IN-1:0]     w_valid_o;
    logic                busy_o, done_o, sat_o;

    longint exp_w[N_IN];
    int     n_chk = 0, n_pass = 0;

    hidden_backprop_seq #(.N_IN(N_IN), .W_W(W_W), .H_W(H_W), .F_W(F_W), .LR_SHIFT(LR)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .start_i(start_i),
        .zero_weight_reset_i(zwr), .target_i(target_i), .final_i(final_i),
        .hidden_val_i(hidden_val_i), .x_i(x_i), .w_i(w_i), .w_o(w_o),
        .w_valid_o(w_valid_o), .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o));

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic longint ref_w(input longint tgt, input longint fin, input longint h,
                                     input longint w, input bit x, output bit sat);
        longint p, d, s;
        sat = 1'b0;
        if (!x || h == 0) return w;
        p = 2 * (tgt - fin) * h;
        d = p / (longint'(1) << LR);
        if (p < 0 && p % (longint'(1) << LR) != 0) d = d - 1;
        s = w + d;
        if (s > 127) begin sat = 1'b1; return 127; end
        if (s < -128) begin sat = 1'b1; return -128; end
        return s;
    endfunction

    function automatic longint w_at(input logic [N_IN*W_W-1:0] v, input int k);
        logic signed [W_W-1:0] b;
        b = v[k*W_W +: W_W];
        return longint'(b);
    endfunction

    task automatic set_in(input int tgt, input int fin, input int h, input logic [N_IN-1:0] x,
                          input int w0, input int w1, input int w2, input int w3);
        int ws[N_IN];
        ws = '{w0, w1, w2, w3};
        target_i = F_W'(tgt);
        final_i = F_W'(fin);
        hidden_val_i = H_W'(h);
        x_i = x;
        for (int k = 0; k < N_IN; k++) w_i[k*W_W +: W_W] = W_W'(ws[k]);
    endtask

    task automatic check_outputs(input string tag, input logic [N_IN-1:0] vexp, input bit sexp);
        for (int k = 0; k < N_IN; k++)
            check($sformatf("%s w%0d", tag, k), w_at(w_o, k), exp_w[k]);
        check({tag, " valid"}, longint'(w_valid_o), longint'(vexp));
        check({tag, " sat"}, longint'(sat_o), longint'(sexp));
    endtask

    task automatic run(input string tag, input int stall_at, input int stall_len, input bit poke);
        longint tgt, fin, h;
        logic [N_IN-1:0] x;
        logic [N_IN*W_W-1:0] w;
        bit sat, s1;
        int e;
        tgt = longint'(target_i); fin = longint'(final_i); h = longint'(hidden_val_i);
        x = x_i; w = w_i;
        sat = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            exp_w[k] = ref_w(tgt, fin, h, w_at(w, k), x[k], s1);
            sat |= s1;
        end
        @(negedge clk_i) start_i = 1'b1;
        @(negedge clk_i) start_i = 1'b0;
        check({tag, " busy"}, longint'(busy_o), 1);
        target_i = F_W'($urandom); final_i = F_W'($urandom);
        hidden_val_i = H_W'($urandom); x_i = N_IN'($urandom); w_i = N_IN*W_W'($urandom);
        for (e = 1; e <= 60; e++) begin
            if (e == stall_at) en_i = 1'b0;
            if (e == stall_at + stall_len) en_i = 1'b1;
            start_i = poke && e == 2;
            @(negedge clk_i);
            if (done_o) break;
        end
        en_i = 1'b1;
        start_i = 1'b0;
        check({tag, " latency"}, e, N_IN + 2 + stall_len);
        check_outputs(tag, '1, sat);
        check({tag, " busy end"}, longint'(busy_o), 0);
        @(negedge clk_i);
        check({tag, " done width"}, longint'(done_o), 0);
        check({tag, " idle"}, longint'(busy_o), 0);
    endtask

    initial begin
        int dones;
        #12;
        check("reset w", longint'(w_o), 0);
        check("reset valid", longint'(w_valid_o), 0);
        check("reset flags", longint'({busy_o, done_o, sat_o}), 0);
        @(negedge clk_i) rst_i = 1'b1;

        set_in(10, 6, 64, 4'b1111, 5, 5, 5, 5);
        run("t1", 0, 0, 0);
        set_in(2, 6, 64, 4'b0101, 5, 5, 5, 5);
        run("t2", 0, 0, 0);
        set_in(1000, 0, 1023, 4'b0011, 100, -100, 3, 4);
        run("t3a", 0, 0, 0);
        set_in(0, 1000, 1023, 4'b1111, -100, -100, -100, -100);
        run("t3b", 0, 0, 0);
        set_in(0, 1, 1, 4'b0001, 0, 0, 0, 0);
        run("t4a", 0, 0, 0);
        check("t4a floor", exp_w[0], -1);
        set_in(0, 1, 0, 4'b0001, 0, 0, 0, 0);
        run("t4b", 0, 0, 0);

        set_in(10, 6, 64, 4'b1111, 5, 5, 5, 5);
        @(negedge clk_i) start_i = 1'b1;
        @(negedge clk_i) start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i) zwr = 1'b1;
        @(negedge clk_i);
        for (int k = 0; k < N_IN; k++) exp_w[k] = 0;
        check_outputs("t5 clear", '0, 1'b0);
        check("t5 busy", longint'(busy_o), 0);
        zwr = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            dones += int'(done_o);
        end
        check("t5 no done", dones, 0);
        set_in(10, 6, 64, 4'b1111, 5, 5, 5, 5);
        run("t5 rerun", 0, 0, 0);

        set_in(2, 6, 64, 4'b1010, 9, 9, 9, 9);
        run("t6 stall", 3, 3, 1);

        set_in(10, 6, 64, 4'b1111, 5, 5, 5, 5);
        @(negedge clk_i) start_i = 1'b1;
        @(negedge clk_i) start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        for (int k = 0; k < N_IN; k++) exp_w[k] = 0;
        check_outputs("t6 arst", '0, 1'b0);
        check("t6 arst flags", longint'({busy_o, done_o}), 0);
        @(negedge clk_i) rst_i = 1'b1;

        for (int i = 0; i < 12; i++) begin
            int t, f;
            t = i % 2 ? $urandom_range(0, 3000) : $urandom_range(0, (1 << F_W) - 1);
            f = i % 2 ? $urandom_range(0, 3000) : $urandom_range(0, (1 << F_W) - 1);
            set_in(t, f, i % 5 == 4 ? 0 : $urandom_range(0, 1023), N_IN'($urandom),
                   $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                   $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
            run($sformatf("rnd%0d", i), $urandom_range(1, 6), $urandom_range(0, 3), i % 3 == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
